// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile: 32-entry general-purpose register file for the single-cycle MIPS
// datapath, sitting directly upstream of the ALU.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset (clears state, $gp/$sp preset)
//   we3    - write enable for write port 3
//   a1/a2  - combinational read addresses (rd1 -> ALU srca, rd2 -> srcb/store)
//   a3     - write address, wd3 - write data
//   rd1    - read data port 1
//   rd2    - read data port 2
//   dbg_a  - debug read address
//   dbg_rd - debug read data, always the committed contents (never bypassed)
//
// Register 0 reads as zero and ignores writes. When BYPASS is set, a write
// pending on the current edge is forwarded to rd1/rd2 in the same cycle.
// ---------------------------------------------------------------------------

// Runtime checker: reports a write attempt whose address is not fully known.
module regfile_checker #(
  parameter int ADDR_W = 5
) (
  input logic              clk,
  input logic              reset,
  input logic              we3,
  input logic [ADDR_W-1:0] a3
);

  // Flag enabled writes that carry an X/Z address at the sampling edge.
  always @(posedge clk) begin
    if (!reset && we3 && $isunknown(a3)) begin
      $error("*E REGFILE runtime: unknown write address %b", a3);
    end
  end

endmodule

module regfile #(
  parameter int               WIDTH    = 32,
  parameter int               ADDR_W   = 5,
  parameter bit               BYPASS   = 1'b1,
  parameter logic [WIDTH-1:0] GP_RESET = 32'h1000_8000,
  parameter logic [WIDTH-1:0] SP_RESET = 32'h7fff_effc
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [WIDTH-1:0]  wd3,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  input  logic [ADDR_W-1:0] dbg_a,
  output logic [WIDTH-1:0]  dbg_rd
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs_r [DEPTH];
  logic             fwd_en_s;

  // Architectural reset value of one register: $gp and $sp are preset.
  function automatic logic [WIDTH-1:0] reset_value(input int idx);
    logic [WIDTH-1:0] val;
    case (idx)
      28:      val = GP_RESET;
      29:      val = SP_RESET;
      default: val = '0;
    endcase
    return val;
  endfunction

  // Storage: async reset wins over any write. Entry 0 is never written.
  // Per-entry decode means an unknown a3 matches no entry, so no write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= reset_value(i);
      end
    end else if (we3) begin
      for (int i = 1; i < DEPTH; i++) begin
        if (a3 == ADDR_W'(i)) begin
          regs_r[i] <= wd3;
        end
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= regs_r[i];
      end
    end
  end

  // Forwarding is only legal when enabled and not in reset (the write would be dropped).
  always_comb begin
    fwd_en_s = 1'b0;
    if (BYPASS && !reset && we3) begin
      fwd_en_s = 1'b1;
    end else begin
      fwd_en_s = 1'b0;
    end
  end

  // Read port 1: zero for r0, forwarded write data on an address hit, else storage.
  always_comb begin
    rd1 = '0;
    if (a1 == '0) begin
      rd1 = '0;
    end else if (fwd_en_s && (a3 == a1)) begin
      rd1 = wd3;
    end else begin
      rd1 = regs_r[a1];
    end
  end

  // Read port 2: same rule as port 1.
  always_comb begin
    rd2 = '0;
    if (a2 == '0) begin
      rd2 = '0;
    end else if (fwd_en_s && (a3 == a2)) begin
      rd2 = wd3;
    end else begin
      rd2 = regs_r[a2];
    end
  end

  // Debug port shows committed state only.
  always_comb begin
    dbg_rd = '0;
    if (dbg_a == '0) begin
      dbg_rd = '0;
    end else begin
      dbg_rd = regs_r[dbg_a];
    end
  end

  regfile_checker #(
    .ADDR_W(ADDR_W)
  ) u_checker (
    .clk   (clk),
    .reset (reset),
    .we3   (we3),
    .a3    (a3)
  );

endmodule

// File: tb/tb_regfile.sv
// ---------------------------------------------------------------------------
// tb_regfile: directed self-checking bench for regfile. Two instances share
// all inputs: dut (BYPASS=1) and dut_nb (BYPASS=0).
// ---------------------------------------------------------------------------
module tb_regfile;

  localparam int          WIDTH  = 32;
  localparam int          ADDR_W = 5;
  localparam logic [31:0] GP     = 32'h1000_8000;
  localparam logic [31:0] SP     = 32'h7fff_effc;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic              we3   = 1'b0;
  logic [ADDR_W-1:0] a1    = '0;
  logic [ADDR_W-1:0] a2    = '0;
  logic [ADDR_W-1:0] a3    = '0;
  logic [WIDTH-1:0]  wd3   = '0;
  logic [ADDR_W-1:0] dbg_a = '0;
  logic [WIDTH-1:0]  rd1, rd2, dbg_rd;
  logic [WIDTH-1:0]  rd1_nb, rd2_nb, dbg_rd_nb;

  logic [WIDTH-1:0]  model [32];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .BYPASS(1'b1),
    .GP_RESET(32'h1000_8000), .SP_RESET(32'h7fff_effc)
  ) dut (
    .clk(clk), .reset(reset), .we3(we3), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
    .rd1(rd1), .rd2(rd2), .dbg_a(dbg_a), .dbg_rd(dbg_rd)
  );

  regfile #(
    .WIDTH(WIDTH), .ADDR_W(ADDR_W), .BYPASS(1'b0),
    .GP_RESET(32'h1000_8000), .SP_RESET(32'h7fff_effc)
  ) dut_nb (
    .clk(clk), .reset(reset), .we3(we3), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
    .rd1(rd1_nb), .rd2(rd2_nb), .dbg_a(dbg_a), .dbg_rd(dbg_rd_nb)
  );

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      model[i] = (i == 28) ? GP : (i == 29) ? SP : 32'h0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      dbg_a = 5'(i);
      #1;
      exp = (i == 28) ? GP : (i == 29) ? SP : 32'h0;
      tests++;
      if (dbg_rd !== exp) begin
        fails++; $display("FAIL reset_dbg[%0d]: got %h expected %h", i, dbg_rd, exp);
      end
      tests++;
      if (dbg_rd_nb !== exp) begin
        fails++; $display("FAIL reset_dbg_nb[%0d]: got %h expected %h", i, dbg_rd_nb, exp);
      end
    end
    a1 = 5'd28; a2 = 5'd29;
    #1;
    tests++;
    if (rd1 !== GP) begin fails++; $display("FAIL reset_rd1_gp: got %h expected %h", rd1, GP); end
    tests++;
    if (rd2 !== SP) begin fails++; $display("FAIL reset_rd2_sp: got %h expected %h", rd2, SP); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_write_read();
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    we3 = 1'b0; a1 = 5'd5; a2 = 5'd5;
    #1;
    model[5] = 32'hDEAD_BEEF;
    tests++;
    if (rd1 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_rd1: got %h expected %h", rd1, 32'hDEAD_BEEF); end
    tests++;
    if (rd2 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_rd2: got %h expected %h", rd2, 32'hDEAD_BEEF); end
    tests++;
    if (rd1_nb !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_rd1_nb: got %h expected %h", rd1_nb, 32'hDEAD_BEEF); end
  endtask

  task automatic test_reg_zero();
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'hFFFF_FFFF; a1 = 5'd0; a2 = 5'd0;
    #1;
    tests++;
    if (rd1 !== 32'h0) begin fails++; $display("FAIL zero_nobypass: got %h expected %h", rd1, 32'h0); end
    tests++;
    if (rd2 !== 32'h0) begin fails++; $display("FAIL zero_nobypass_rd2: got %h expected %h", rd2, 32'h0); end
    @(posedge clk); #1;
    we3 = 1'b0; dbg_a = 5'd0;
    #1;
    tests++;
    if (rd1 !== 32'h0) begin fails++; $display("FAIL zero_rd1: got %h expected %h", rd1, 32'h0); end
    tests++;
    if (dbg_rd !== 32'h0) begin fails++; $display("FAIL zero_dbg: got %h expected %h", dbg_rd, 32'h0); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'h0000_0001;
    @(posedge clk); #1;
    we3 = 1'b0;
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'h1234_5678; a1 = 5'd7; a2 = 5'd7; dbg_a = 5'd7;
    #1;
    tests++;
    if (rd1 !== 32'h1234_5678) begin fails++; $display("FAIL byp_rd1: got %h expected %h", rd1, 32'h1234_5678); end
    tests++;
    if (rd2 !== 32'h1234_5678) begin fails++; $display("FAIL byp_rd2: got %h expected %h", rd2, 32'h1234_5678); end
    tests++;
    if (dbg_rd !== 32'h1) begin fails++; $display("FAIL byp_dbg_old: got %h expected %h", dbg_rd, 32'h1); end
    tests++;
    if (rd1_nb !== 32'h1) begin fails++; $display("FAIL nobyp_rd1_old: got %h expected %h", rd1_nb, 32'h1); end
    tests++;
    if (rd2_nb !== 32'h1) begin fails++; $display("FAIL nobyp_rd2_old: got %h expected %h", rd2_nb, 32'h1); end
    @(posedge clk); #1;
    we3 = 1'b0;
    #1;
    model[7] = 32'h1234_5678;
    tests++;
    if (rd1_nb !== 32'h1234_5678) begin fails++; $display("FAIL nobyp_rd1_new: got %h expected %h", rd1_nb, 32'h1234_5678); end
    tests++;
    if (rd1 !== 32'h1234_5678) begin fails++; $display("FAIL byp_rd1_stored: got %h expected %h", rd1, 32'h1234_5678); end
    tests++;
    if (dbg_rd !== 32'h1234_5678) begin fails++; $display("FAIL byp_dbg_new: got %h expected %h", dbg_rd, 32'h1234_5678); end
  endtask

  task automatic test_two_ports();
    @(negedge clk);
    a1 = 5'd5; a2 = 5'd7;
    #1;
    tests++;
    if (rd1 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL twoport_rd1: got %h expected %h", rd1, 32'hDEAD_BEEF); end
    tests++;
    if (rd2 !== 32'h1234_5678) begin fails++; $display("FAIL twoport_rd2: got %h expected %h", rd2, 32'h1234_5678); end
  endtask

  task automatic test_write_enable();
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'h0000_0033;
    @(posedge clk); #1;
    we3 = 1'b0; a3 = 5'd3; wd3 = 32'h0000_0099; a1 = 5'd3;
    @(posedge clk); #1;
    dbg_a = 5'd3;
    #1;
    model[3] = 32'h33;
    tests++;
    if (dbg_rd !== 32'h33) begin fails++; $display("FAIL we0_dbg: got %h expected %h", dbg_rd, 32'h33); end
    tests++;
    if (rd1 !== 32'h33) begin fails++; $display("FAIL we0_rd1: got %h expected %h", rd1, 32'h33); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    we3 = 1'b1; a3 = 5'd10; wd3 = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    we3 = 1'b0; dbg_a = 5'd10;
    #1;
    tests++;
    if (dbg_rd !== 32'hA5A5_A5A5) begin fails++; $display("FAIL ar_pre: got %h expected %h", dbg_rd, 32'hA5A5_A5A5); end
    #1 reset = 1'b1;
    #1;
    tests++;
    if (dbg_rd !== 32'h0) begin fails++; $display("FAIL ar_async_clear: got %h expected %h", dbg_rd, 32'h0); end
    we3 = 1'b1; a3 = 5'd10; wd3 = 32'h5; a1 = 5'd10;
    #1;
    tests++;
    if (rd1 !== 32'h0) begin fails++; $display("FAIL ar_no_bypass: got %h expected %h", rd1, 32'h0); end
    @(posedge clk); #1;
    tests++;
    if (dbg_rd !== 32'h0) begin fails++; $display("FAIL ar_write_dropped: got %h expected %h", dbg_rd, 32'h0); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (dbg_rd !== 32'h0) begin fails++; $display("FAIL ar_release_hold: got %h expected %h", dbg_rd, 32'h0); end
    @(posedge clk); #1;
    we3 = 1'b0;
    tests++;
    if (dbg_rd !== 32'h5) begin fails++; $display("FAIL ar_first_write: got %h expected %h", dbg_rd, 32'h5); end
    model_reset();
    model[10] = 32'h5;
  endtask

  task automatic test_unknown_addr();
    logic [ADDR_W-1:0] ax;
    ax = 5'bx;
    @(negedge clk);
    we3 = 1'b1; a3 = ax; wd3 = 32'hCAFE_F00D;
    @(posedge clk); #1;
    we3 = 1'b0; a3 = 5'd0;
    // A two-state simulator resolves the X to some known address; model that write.
    if (!$isunknown(ax) && ax != 5'd0) begin
      model[ax] = 32'hCAFE_F00D;
    end
    for (int i = 0; i < 32; i++) begin
      dbg_a = 5'(i);
      #1;
      tests++;
      if (dbg_rd !== model[i]) begin
        fails++; $display("FAIL xaddr_snapshot[%0d]: got %h expected %h", i, dbg_rd, model[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_reg_zero();
    test_bypass();
    test_two_ports();
    test_write_enable();
    test_async_reset();
    test_unknown_addr();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32-entry general-purpose register file for the single-cycle MIPS datapath; sits directly upstream of the ALU.
- Read port 1 drives ALU srca. Read port 2 drives the srcb mux and the store-data path.
- The write port takes the writeback value (ALU result or load data) on the rising clock edge.
- Holds architectural state. Register 0 is hardwired to zero. $gp and $sp take defined reset values.

Parameters:
- WIDTH, 32, data width of each register and of all data ports.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports; when 0 reads return the old value.
- GP_RESET, 32'h1000_8000, reset value of register 28 ($gp).
- SP_RESET, 32'h7fff_effc, reset value of register 29 ($sp).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- we3  input  1  write enable for port 3.
- a1  input  ADDR_W  read address, port 1.
- a2  input  ADDR_W  read address, port 2.
- a3  input  ADDR_W  write address, port 3.
- wd3  input  WIDTH  write data, port 3.
- rd1  output  WIDTH  read data, port 1 (to ALU srca).
- rd2  output  WIDTH  read data, port 2 (to srcb mux / store data).
- dbg_a  input  ADDR_W  testbench/debug read address.
- dbg_rd  output  WIDTH  debug read data. Never bypassed; always shows committed state.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Storage: 2**ADDR_W registers of WIDTH bits.
- Reset:
  - reset high clears every register to 0 immediately, without waiting for a clock edge.
  - Exceptions: reg 28 = GP_RESET, reg 29 = SP_RESET.
  - Reset has priority over any write in the same cycle. A write with reset high is dropped.
  - Deassertion is seen at the next rising edge; a write on that edge is accepted.
- Outputs while in reset follow the combinational read rule over the reset contents: rd1/rd2/dbg_rd = 0, or GP_RESET / SP_RESET when addressing 28 / 29.
- Write:
  - On rising clk with reset low and we3 == 1, reg[a3] <= wd3.
  - a3 == 0: write ignored; reg 0 stays 0 permanently.
  - we3 == 0: no state change.
- Read (combinational, zero latency):
  - rd1 = (a1 == 0) ? 0 : reg[a1]; rd2 likewise with a2.
  - New data becomes visible after the write edge.
- Bypass (BYPASS = 1 only):
  - If we3 && a3 != 0 && a3 == a1, then rd1 = wd3 in the same cycle; same rule for rd2/a2.
  - Reset high disables bypass.
- BYPASS = 0: rd1/rd2 show pre-edge contents until the edge.
- Simultaneous events:
  - a1 == a2: both ports return the same value.
  - a1 == a2 == a3 with we3: both ports bypass.
  - Reading 0 while writing 0: returns 0.
- Unknown inputs: if we3 == 1 and a3 contains X/Z at the clock edge, raise $error("*E REGFILE runtime: unknown write address %b", a3) and perform no write.
- No X on rd1/rd2 after reset for any known address.

Test Plan:
- Reset values: reset=1 for 2 cycles; sweep dbg_a 0..31 -> dbg_rd = 0 everywhere except reg28 = 32'h1000_8000 and reg29 = 32'h7fff_effc.
- Write then read: we3=1, a3=5, wd3=32'hDEAD_BEEF, edge; then a1=5, a2=5 -> rd1 = rd2 = 32'hDEAD_BEEF.
- Register zero: we3=1, a3=0, wd3=32'hFFFF_FFFF, edge; a1=0 -> rd1 = 0 and dbg_rd(0) = 0. Same cycle with a1=0: rd1 = 0, no bypass.
- Bypass, BYPASS=1:
  - Prior reg7 = 32'h1.
  - Set we3=1, a3=7, wd3=32'h1234_5678, a1=7 before the edge.
  - Before the edge: rd1 = 32'h1234_5678 while dbg_rd(7) = 32'h1.
  - Repeat with BYPASS=0 -> rd1 = 32'h1 until the edge, then 32'h1234_5678.
- Async reset mid-operation:
  - Write reg10 = 32'hA5A5_A5A5.
  - Raise reset between edges -> dbg_rd(10) = 0 before the next edge.
  - Hold reset with we3=1, a3=10, wd3=32'h5 across an edge -> reg10 stays 0.
- Write enable and unknown address:
  - we3=0 with a3=3, wd3=32'h99 -> reg3 unchanged.
  - we3=1, a3=5'bx -> $error fires and no register changes (full dbg_a sweep matches the prior snapshot).
